// File: rtl/calc_seq_if.sv
// calc_seq_if: bundles the sequencer's control bus.
//   Front end -> seq : init, op, b_zero
//   Sub-units -> seq : b2b_done, alu_done, b2d_done (level signals)
//   seq -> sub-units : b2b_init, b2b_sel, ld_a, ld_b, alu_init, alu_sel,
//                      b2d_init, ld_res
//   seq -> front end : busy, done, err
// master = the sequencer, slave = everything around it.
interface calc_seq_if;
    logic       init;
    logic [1:0] op;
    logic       b_zero;
    logic       b2b_done;
    logic       alu_done;
    logic       b2d_done;
    logic       b2b_init;
    logic       b2b_sel;
    logic       ld_a;
    logic       ld_b;
    logic       alu_init;
    logic [1:0] alu_sel;
    logic       b2d_init;
    logic       ld_res;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  init, op, b_zero, b2b_done, alu_done, b2d_done,
        output b2b_init, b2b_sel, ld_a, ld_b, alu_init, alu_sel,
               b2d_init, ld_res, busy, done, err
    );

    modport slave (
        output init, op, b_zero, b2b_done, alu_done, b2d_done,
        input  b2b_init, b2b_sel, ld_a, ld_b, alu_init, alu_sel,
               b2d_init, ld_res, busy, done, err
    );
endinterface

// File: rtl/calc_seq.sv
// calc_seq: top-level sequencer for the calculator datapath.
// Runs operand A and operand B through the shared BCD-to-binary converter,
// starts the selected arithmetic unit, then the binary-to-BCD converter.
// Sub-units hold done high for a long time, so each converter step waits
// for done to rise (WAIT_*) and then to fall again (REL_*) before reuse.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - calc_seq_if.master (start/op/b_zero in, unit dones in,
//          strobes/selects out, busy/done/err out)
// Optional build macro CALC_SEQ_TIMEOUT_EN: adds an 8-bit wait counter that
// aborts with err after TIMEOUT cycles in any WAIT_*/REL_* state.
module calc_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    calc_seq_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CONV_A = 4'd1,
        WAIT_A = 4'd2,
        CAP_A  = 4'd3,
        REL_A  = 4'd4,
        CONV_B = 4'd5,
        WAIT_B = 4'd6,
        CAP_B  = 4'd7,
        REL_B  = 4'd8,
        EXEC   = 4'd9,
        WAIT_X = 4'd10,
        TOBCD  = 4'd11,
        WAIT_D = 4'd12,
        FIN    = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt_q, to_cnt_d;
    logic       is_wait;
    logic       to_hit;

    assign is_wait = state_q inside {WAIT_A, REL_A, WAIT_B, REL_B, WAIT_X, WAIT_D};
    // Abort on the edge at which the counter would reach TIMEOUT, so the
    // FSM is back in IDLE exactly TIMEOUT cycles after entering the wait.
    assign to_hit  = is_wait && (to_cnt_q == TO_LAST);

    // Any state change restarts the count; staying in a wait state counts up.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d != state_q)
            to_cnt_d = 8'd0;
        else if (is_wait && to_cnt_q != TO_MAX)
            to_cnt_d = to_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt_q <= 8'd0;
        else      to_cnt_q <= to_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next state plus Moore output decode.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        err_d        = err_q;
        bus.b2b_init = 1'b0;
        bus.b2b_sel  = 1'b0;
        bus.ld_a     = 1'b0;
        bus.ld_b     = 1'b0;
        bus.alu_init = 1'b0;
        bus.b2d_init = 1'b0;
        bus.ld_res   = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.init) begin
                    op_d    = bus.op;
                    err_d   = 1'b0;
                    state_d = CONV_A;
                end
            end
            CONV_A: begin
                bus.b2b_init = 1'b1;
                state_d      = WAIT_A;
            end
            WAIT_A: if (bus.b2b_done) state_d = CAP_A;
            CAP_A: begin
                bus.ld_a = 1'b1;
                state_d  = REL_A;
            end
            // Converter ignores init while its done is still high.
            REL_A: if (!bus.b2b_done) state_d = CONV_B;
            CONV_B: begin
                bus.b2b_sel  = 1'b1;
                bus.b2b_init = 1'b1;
                state_d      = WAIT_B;
            end
            WAIT_B: begin
                bus.b2b_sel = 1'b1;
                if (bus.b2b_done) state_d = CAP_B;
            end
            CAP_B: begin
                bus.b2b_sel = 1'b1;
                bus.ld_b    = 1'b1;
                // Divide by zero: flag it and never start the ALU.
                if (op_q == 2'b11 && bus.b_zero) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = REL_B;
                end
            end
            REL_B: begin
                bus.b2b_sel = 1'b1;
                if (!bus.b2b_done) state_d = EXEC;
            end
            EXEC: begin
                bus.alu_init = 1'b1;
                state_d      = WAIT_X;
            end
            WAIT_X: if (bus.alu_done) state_d = TOBCD;
            TOBCD: begin
                bus.b2d_init = 1'b1;
                state_d      = WAIT_D;
            end
            WAIT_D: if (bus.b2d_done) state_d = FIN;
            FIN: begin
                bus.ld_res = 1'b1;
                bus.done   = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                bus.busy = 1'b0;
                state_d  = IDLE;
            end
        endcase

`ifdef CALC_SEQ_TIMEOUT_EN
        // A wait that is still pending at the limit is abandoned.
        if (to_hit && state_d == state_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    assign bus.alu_sel = op_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: self-checking bench for calc_seq. Behavioural sub-units
// raise done D cycles after accepting init and hold it H cycles; each run is
// compared against transaction-level expectations (pulse counts, ordering,
// latency computed from D/H, err on divide by zero).
module tb_calc_seq;

    localparam int TO = 20;
`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int HOLD_LONG = 15;
`else
    localparam int HOLD_LONG = 31;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    calc_seq_if bus();

    calc_seq #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sub-unit models: 0 = BCD-to-binary, 1 = ALU, 2 = binary-to-BCD.
    int       ph [3];
    int       ud [3];
    int       uh [3];
    logic [2:0] u_init;

    assign u_init = {bus.b2d_init, bus.alu_init, bus.b2b_init};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) ph[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ph[i] == 0) begin
                    if (u_init[i]) ph[i] <= 1;
                end else if (ph[i] >= ud[i] + uh[i] - 1) begin
                    ph[i] <= 0;
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    always_comb begin
        bus.b2b_done = 1'b0;
        bus.alu_done = 1'b0;
        bus.b2d_done = 1'b0;
        bus.b2b_done = (ph[0] != 0) && (ph[0] >= ud[0]);
        bus.alu_done = (ph[1] != 0) && (ph[1] >= ud[1]);
        bus.b2d_done = (ph[2] != 0) && (ph[2] >= ud[2]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.b2b_init, bus.b2b_sel, bus.ld_a, bus.ld_b, bus.alu_init,
                bus.alu_sel, bus.b2d_init, bus.ld_res, bus.busy, bus.done, bus.err};
    endfunction

    task automatic wait_units();
        bit idle = 1'b0;
        for (int k = 0; k < 5000 && !idle; k++) begin
            @(negedge clk);
            idle = (ph[0] == 0) && (ph[1] == 0) && (ph[2] == 0);
        end
        chk("units_idle", 32'(idle), 32'd1);
        @(negedge clk);
    endtask

    // One full request; called at a negedge with the DUT idle.
    task automatic run(input string tag, input logic [1:0] op, input logic bz,
                       input int db, input int hb, input int da, input int ha,
                       input int dd, input int hd, input bit tog, input bit poke);
        bit   div0;
        int   exp_lat, pa;
        int   n_b2b = 0, b2b_ovl = 0, n_lda = 0, n_ldb = 0, sel_bad = 0;
        int   n_alu = 0, n_b2d = 0, n_res = 0, n_done = 0, done_n = 0;
        int   alu_n = 0, asel_bad = 0;
        logic [1:0] sel_seq = 2'b00;
        logic err_start = 1'b1, err_end = 1'b0;
        bit   ended = 1'b0;

        ud[0] = db; uh[0] = hb; ud[1] = da; uh[1] = ha; ud[2] = dd; uh[2] = hd;
        div0    = (op == 2'b11) && bz;
        pa      = (db + 3 > db + hb + 1) ? db + 3 : db + hb + 1;
        exp_lat = 1 + 2 * pa + (da + 1) + (dd + 1);

        bus.op     = op;
        bus.b_zero = bz;
        bus.init   = 1'b1;
        @(negedge clk);
        for (int n = 1; n < 3000 && !ended; n++) begin
            bus.init = 1'b0;
            if (n == 1) err_start = bus.err;
            if (n > 1 && !bus.busy) begin
                ended   = 1'b1;
                err_end = bus.err;
            end else begin
                if (bus.b2b_init) begin
                    if (n_b2b < 2) sel_seq[n_b2b] = bus.b2b_sel;
                    n_b2b++;
                    if (bus.b2b_done) b2b_ovl++;
                end
                if (bus.ld_a) begin n_lda++; if (bus.b2b_sel !== 1'b0) sel_bad++; end
                if (bus.ld_b) begin n_ldb++; if (bus.b2b_sel !== 1'b1) sel_bad++; end
                if (bus.alu_init) begin n_alu++; alu_n = n; end
                if (bus.b2d_init) n_b2d++;
                if (bus.ld_res) n_res++;
                if (bus.done) begin n_done++; done_n = n; end
                if (bus.alu_sel !== op) asel_bad++;
                if (tog && n == 3) bus.op = ~op;
                if (poke && alu_n != 0 && n == alu_n + 1) bus.init = 1'b1;
                @(negedge clk);
            end
        end
        bus.init = 1'b0;
        chk({tag, ".ended"},     32'(ended),     32'd1);
        chk({tag, ".err_start"}, 32'(err_start), 32'd0);
        chk({tag, ".err_end"},   32'(err_end),   32'(div0));
        chk({tag, ".b2b_cnt"},   32'(n_b2b),     32'd2);
        chk({tag, ".b2b_sel"},   32'(sel_seq),   32'b10);
        chk({tag, ".b2b_ovl"},   32'(b2b_ovl),   32'd0);
        chk({tag, ".ld_a"},      32'(n_lda),     32'd1);
        chk({tag, ".ld_b"},      32'(n_ldb),     32'd1);
        chk({tag, ".ld_sel"},    32'(sel_bad),   32'd0);
        chk({tag, ".alu_init"},  32'(n_alu),     div0 ? 32'd0 : 32'd1);
        chk({tag, ".b2d_init"},  32'(n_b2d),     div0 ? 32'd0 : 32'd1);
        chk({tag, ".ld_res"},    32'(n_res),     div0 ? 32'd0 : 32'd1);
        chk({tag, ".done_cnt"},  32'(n_done),    div0 ? 32'd0 : 32'd1);
        chk({tag, ".alu_sel"},   32'(asel_bad),  32'd0);
        chk({tag, ".alu_sel_idle"}, 32'(bus.alu_sel), 32'(op));
        if (!div0) chk({tag, ".latency"}, 32'(done_n), 32'(exp_lat));
        wait_units();
    endtask

    initial begin
        bus.init   = 1'b0;
        bus.op     = 2'b00;
        bus.b_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin ud[i] = 1; uh[i] = 1; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs()), 32'd0);

        // Slow units with long done hold, op add
        run("add_slow", 2'b00, 1'b0, 3, HOLD_LONG, 3, HOLD_LONG, 3, HOLD_LONG, 1'b0, 1'b0);
        // Divide by zero aborts before the ALU
        run("div_zero", 2'b11, 1'b1, 2, 4, 1, 1, 1, 1, 1'b0, 1'b0);
        chk("err_held", 32'(bus.err), 32'd1);
        // Ideal units: 13-cycle latency, op toggled mid-run
        run("ideal_mul", 2'b10, 1'b0, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0);
        // Divide with nonzero B; init re-pulsed while waiting on the ALU
        run("div_poke", 2'b11, 1'b0, 2, 2, 4, 3, 2, 2, 1'b0, 1'b1);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            logic [1:0] rop;
            logic       rbz;
            rop = 2'($urandom_range(0, 3));
            rbz = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", r), rop, rbz,
                $urandom_range(1, 4), $urandom_range(1, 12),
                $urandom_range(1, 4), $urandom_range(1, 12),
                $urandom_range(1, 4), $urandom_range(1, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during WAIT_B
        begin
            bit seen = 1'b0;
            ud[0] = 3; uh[0] = 5; ud[1] = 1; uh[1] = 1; ud[2] = 1; uh[2] = 1;
            bus.op = 2'b01; bus.b_zero = 1'b0; bus.init = 1'b1;
            @(negedge clk);
            bus.init = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                if (bus.b2b_init && bus.b2b_sel) seen = 1'b1;
                @(negedge clk);
            end
            chk("rst.reach_wait_b", 32'(seen), 32'd1);
            chk("rst.busy_before", 32'(bus.busy), 32'd1);
            #1 rst = 1'b0;
            #1 chk("rst.async_outs", 32'(outs()), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("rst.idle_after", 32'(outs()), 32'd0);
            run("post_rst", 2'b01, 1'b0, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
        end

        // ALU never finishes
        begin
            bit seen = 1'b0;
            ud[0] = 1; uh[0] = 1; ud[1] = 100000; uh[1] = 1; ud[2] = 1; uh[2] = 1;
            bus.op = 2'b00; bus.init = 1'b1;
            @(negedge clk);
            bus.init = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                if (bus.alu_init) seen = 1'b1;
                else @(negedge clk);
            end
            chk("to.reach_exec", 32'(seen), 32'd1);
`ifdef CALC_SEQ_TIMEOUT_EN
            repeat (TO) @(negedge clk);
            chk("to.busy_last", 32'(bus.busy), 32'd1);
            @(negedge clk);
            chk("to.busy_drop", 32'(bus.busy), 32'd0);
            chk("to.err", 32'(bus.err), 32'd1);
`else
            repeat (300) @(negedge clk);
            chk("to.still_busy", 32'(bus.busy), 32'd1);
            chk("to.no_err", 32'(bus.err), 32'd0);
`endif
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
